// File: rtl/i2c_slave.sv
// I2C target: synchronized SCL/SDA sampling, START/STOP detection,
// 7-bit address match and byte-level rx/tx handshakes.
// Optional clock stretching when I2C_SLAVE_STRETCH_EN is defined.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic [3:0] status
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] RX_BYTE   = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] TX_BYTE   = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

`ifdef I2C_SLAVE_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl, sda;
    logic       scl_rise, scl_fall, start_ev, stop_ev;
    logic       load_fall;
    logic [2:0] state, bit_cnt;
    logic [7:0] shift_reg, tx_shift;
    logic       rw, addressed, ack_pend, rx_stall;
    logic       hold_rx, hold_tx, scl_hold;
    logic       start_det, stop_det;

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start_ev = scl & scl_d & sda_d & ~sda;
    assign stop_ev  = scl & scl_d & ~sda_d & sda;
    assign status   = {addressed, rw, start_det, stop_det};

    // Falls where the next read byte is taken from the user side
    assign load_fall = scl_fall &
                       ((state == ADDR_ACK && rw) ||
                        (state == TX_ACK && ack_pend));

`ifdef I2C_SLAVE_STRETCH_EN
    assign scl_oe = scl_hold;
`else
    assign scl_oe = 1'b0;
`endif

    // Pad synchronizers plus one-cycle delayed copies for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl;
            sda_d    <= sda;
        end
    end

    // Protocol FSM: bus events first, then stretch service, then bit steps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            tx_shift  <= 8'hFF;
            rw        <= 1'b0;
            addressed <= 1'b0;
            ack_pend  <= 1'b0;
            rx_stall  <= 1'b0;
            hold_rx   <= 1'b0;
            hold_tx   <= 1'b0;
            scl_hold  <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (scl_hold && !hold_rx && !hold_tx)
                scl_hold <= 1'b0;
            if (stop_ev || start_ev) begin
                state     <= stop_ev ? IDLE : ADDR;
                bit_cnt   <= 3'd0;
                sda_oe    <= 1'b0;
                ack_pend  <= 1'b0;
                rx_stall  <= 1'b0;
                hold_rx   <= 1'b0;
                hold_tx   <= 1'b0;
                scl_hold  <= 1'b0;
                start_det <= start_ev;
                stop_det  <= stop_ev;
                if (stop_ev)
                    addressed <= 1'b0;
            end else if (hold_rx) begin
                if (rx_ready) begin
                    hold_rx  <= 1'b0;
                    rx_valid <= 1'b1;
                    sda_oe   <= 1'b1;
                    state    <= RX_ACK;
                end
            end else if (hold_tx) begin
                if (tx_valid) begin
                    hold_tx  <= 1'b0;
                    tx_shift <= tx_data;
                    sda_oe   <= ~tx_data[7];
                    bit_cnt  <= 3'd1;
                    state    <= TX_BYTE;
                end
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_reg[6:0] == SLAVE_ADDR) begin
                                    rw        <= sda;
                                    addressed <= 1'b1;
                                    ack_pend  <= 1'b1;
                                    tx_req    <= sda;
                                end else begin
                                    addressed <= 1'b0;
                                    state     <= WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && ack_pend) begin
                            sda_oe   <= 1'b1;
                            ack_pend <= 1'b0;
                            state    <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (!rw)
                                state <= RX_BYTE;
                        end
                    end
                    RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data <= {shift_reg[6:0], sda};
                                if (rx_ready) begin
                                    rx_valid <= 1'b1;
                                    ack_pend <= 1'b1;
                                end else if (STRETCH) begin
                                    rx_stall <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && ack_pend) begin
                            sda_oe   <= 1'b1;
                            ack_pend <= 1'b0;
                            state    <= RX_ACK;
                        end else if (scl_fall && rx_stall) begin
                            rx_stall <= 1'b0;
                            hold_rx  <= 1'b1;
                            scl_hold <= 1'b1;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= RX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[6:0], 1'b1};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                tx_req   <= 1'b1;
                                ack_pend <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
                if (load_fall) begin
                    ack_pend <= 1'b0;
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        sda_oe   <= ~tx_data[7];
                        bit_cnt  <= 3'd1;
                        state    <= TX_BYTE;
                    end else if (STRETCH) begin
                        sda_oe   <= 1'b0;
                        hold_tx  <= 1'b1;
                        scl_hold <= 1'b1;
                    end else begin
                        tx_shift <= 8'hFF;
                        sda_oe   <= 1'b0;
                        bit_cnt  <= 3'd1;
                        state    <= TX_BYTE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder): the peer of the team's I2C master, for loopback benches and for on-chip register access from an external I2C host.
- Samples open-drain SCL/SDA with the system clock, detects START/STOP, and matches a 7-bit address.
- Receives write bytes and transmits read bytes over a byte-level valid/ready interface toward user logic.
- Standard/fast mode only; clk must be ≥ 20× the SCL rate.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this target ACKs.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- sda_oe  out  1  1 = pull SDA low; pad drives 0 when set, Z otherwise
- scl_oe  out  1  1 = hold SCL low (clock stretch); constant 0 unless I2C_SLAVE_STRETCH_EN
- rx_data  out  8  last received data byte
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_ready  in  1  user can accept a byte; sampled at 8th data bit
- tx_data  in  8  byte to send on read
- tx_valid  in  1  tx_data present
- tx_req  out  1  one-cycle pulse, next read byte needed
- status  out  4  {addressed, rw, start_det, stop_det}; start_det/stop_det are one-cycle pulses

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, status=4'h0, FSM=IDLE.
- Reset mid-transfer releases SDA and SCL immediately; reset is asynchronous.
- SCL/SDA pass through SYNC_STAGES flops. Edges are detected on the synced value vs. its 1-cycle delayed copy.
- Bus event latency: SYNC_STAGES+1 clk.
- START: synced SDA falls while synced SCL is high. Valid in any state, including repeated START. Goes to ADDR; bit counter cleared; sda_oe released; start_det pulses.
- STOP: synced SDA rises while synced SCL is high. Goes to IDLE from any state; sda_oe=0; addressed=0; stop_det pulses.
- Data sampled on SCL rising edge, MSB first. sda_oe changes only on the clk cycle that detects an SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- ADDR: shift 8 bits.
  - On 8th rise, compare [7:1] with SLAVE_ADDR.
  - Match: on next fall assert sda_oe (ACK) and go to ADDR_ACK; latch rw=bit0; addressed=1.
  - Mismatch: go to WAIT_STOP, never drive SDA. A new START still restarts ADDR.
- ADDR_ACK: on the fall ending the ACK bit, release SDA and go to RX_BYTE (rw=0) or TX_BYTE (rw=1).
  - For rw=1, tx_req pulses on the 8th address rise, and tx_data is latched on this fall.
  - MSB drives sda_oe = ~tx_data[7] in the same cycle.
- RX_BYTE:
  - On 8th rise: rx_data updated.
  - If rx_ready=1: rx_valid pulses (same cycle) and ACK is driven on next fall.
  - If rx_ready=0: no rx_valid, NACK (SDA released), go to WAIT_STOP.
- RX_ACK: release on the closing fall, then return to RX_BYTE.
- TX_BYTE:
  - Bits 6..0 are driven on successive falls.
  - After the 8th bit's fall, release SDA and go to TX_ACK.
- TX_ACK: sample master ACK on the rise.
  - ACK (SDA=0): pulse tx_req; on the closing fall, latch tx_data and start the next byte.
  - NACK: go to WAIT_STOP.
- tx_valid=0 at the latch fall: send 8'hFF (SDA released for the whole byte).
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined — RX path: when the 8th RX bit rises with rx_ready=0, assert scl_oe from the next SCL fall until rx_ready=1. Then pulse rx_valid, ACK, and release scl_oe one clk after sda_oe is set.
- Defined — TX path: at a TX latch fall with tx_valid=0, hold scl_oe until tx_valid=1. Then latch tx_data, drive the MSB, and release scl_oe one clk later.
- Defined — STOP or reset releases scl_oe.
- Not defined: scl_oe tied 0; behaviour exactly as in Behaviour.

Test Plan:
- START, address 0x84 (0x42 write), bytes 0xA5, 0x3C, STOP, rx_ready=1 → ACK on all 3 bytes; rx_valid pulses twice with 0xA5 then 0x3C; stop_det pulses once.
- START, address 0x8A (0x45 write), byte 0xFF → sda_oe never asserted; rx_valid never pulses.
- START, 0x85, tx_data=0x96 then 0x01, master ACK then NACK, STOP → SDA bits 10010110 and 00000001; tx_req pulses twice; WAIT_STOP→IDLE.
- Write 0x84, 0x11, repeated START, 0x85 read → rw flips 0→1; addressed stays 1; tx_req pulses after 2nd address.
- rx_ready=0 at 2nd byte → NACK on that byte, no rx_valid. With I2C_SLAVE_STRETCH_EN: scl_oe=1 until rx_ready rises, then ACK.
- reset_n low mid TX_BYTE while sda_oe=1 → sda_oe=0, status=0 immediately; ignores bus until next START.
